// File: rtl/playback_serializer.sv
`default_nettype none
// ============================================================================
// Module  : playback_serializer
// Purpose : fetches stored audio words from block RAM and shifts them out
//           MSB-first on a 1-bit line at CLK_DIV clocks per bit
// Rev     : 1.0  initial release
// ============================================================================
module playback_serializer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int CLK_DIV      = 49,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  audio_out,
    output logic                  busy,
    output logic                  done
);

    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [C_DIV_W-1:0]    C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_DIV_W-1:0]    C_DIV_ONE  = C_DIV_W'(1);
    localparam logic [C_BIT_W-1:0]    C_BIT_LAST = C_BIT_W'(DATA_WIDTH - 1);
    localparam logic [C_BIT_W-1:0]    C_BIT_ONE  = C_BIT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_TWO = ADDR_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH0 = 2'd1,
        S_WAIT0  = 2'd2,
        S_SHIFT  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ADDR_WIDTH-1:0]   r_end_addr;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [C_DIV_W-1:0]      r_div;
    logic [C_BIT_W-1:0]      r_bit;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [READ_LATENCY-1:0] w_pipe_next;

    logic                    w_rd_valid;
    logic                    w_abort;
    logic                    w_accept;
    logic                    w_load_first;
    logic                    w_bit_tick;
    logic                    w_word_end;
    logic                    w_finish;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [ADDR_WIDTH-1:0]   w_next2_addr;

    // Read-valid tracker: a token per mem_en pulse, emerging when its data is on mem_rdata
    generate
        if (READ_LATENCY > 1) begin : g_pipe_deep
            assign w_pipe_next = {r_rd_pipe[READ_LATENCY-2:0], mem_en};
        end else begin : g_pipe_single
            assign w_pipe_next = mem_en;
        end
    endgenerate

    assign w_rd_valid   = r_rd_pipe[READ_LATENCY-1];
    assign w_next_addr  = r_cur_addr + C_ADDR_ONE;
    assign w_next2_addr = r_cur_addr + C_ADDR_TWO;
    assign audio_out    = r_shift[DATA_WIDTH-1];
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        w_accept     = 1'b0;
        w_load_first = 1'b0;
        w_bit_tick   = 1'b0;
        w_word_end   = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_accept     = 1'b1;
                    w_next_state = S_FETCH0;
                end
            end
            S_FETCH0: begin
                if (stop) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (stop) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_rd_valid) begin
                    w_load_first = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (stop) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_div == C_DIV_LAST) begin
                    w_bit_tick = 1'b1;
                    if (r_bit == C_BIT_LAST) begin
                        w_word_end = 1'b1;
                        if (r_cur_addr == r_end_addr) begin
                            w_finish     = 1'b1;
                            w_next_state = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            done       <= 1'b0;
            r_end_addr <= '0;
            r_cur_addr <= '0;
            r_shift    <= '0;
            r_hold     <= '0;
            r_div      <= '0;
            r_bit      <= '0;
            r_rd_pipe  <= '0;
        end else begin
            mem_en    <= 1'b0;
            done      <= 1'b0;
            r_rd_pipe <= w_pipe_next;
            if (w_abort) begin
                // Reads already issued are left to complete in the RAM but never captured
                r_shift   <= '0;
                r_div     <= '0;
                r_bit     <= '0;
                r_rd_pipe <= '0;
            end else begin
                if (w_accept) begin
                    mem_en     <= 1'b1;
                    mem_addr   <= '0;
                    r_end_addr <= end_addr;
                    r_cur_addr <= '0;
                end
                if (w_load_first) begin
                    r_shift <= mem_rdata;
                    r_div   <= '0;
                    r_bit   <= '0;
                    if (r_cur_addr < r_end_addr) begin
                        mem_en   <= 1'b1;
                        mem_addr <= w_next_addr;
                    end
                end
                if (r_state == S_SHIFT) begin
                    if (w_rd_valid) begin
                        r_hold <= mem_rdata;
                    end
                    if (w_bit_tick) begin
                        r_div <= '0;
                        if (w_finish) begin
                            r_shift <= '0;
                            r_bit   <= '0;
                            done    <= 1'b1;
                        end else if (w_word_end) begin
                            // Next word enters on the edge the following bit starts: no gap
                            r_shift    <= r_hold;
                            r_bit      <= '0;
                            r_cur_addr <= w_next_addr;
                            if (w_next_addr < r_end_addr) begin
                                mem_en   <= 1'b1;
                                mem_addr <= w_next2_addr;
                            end
                        end else begin
                            r_bit   <= r_bit + C_BIT_ONE;
                            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + C_DIV_ONE;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_playback_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_playback_serializer
// Purpose : directed self-checking bench for playback_serializer
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_playback_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Instance A: 16-bit addresses
    logic        start_a, stop_a;
    logic [15:0] end_a;
    logic        mem_en_a;
    logic [15:0] mem_addr_a;
    logic [15:0] rdata_a;
    logic        audio_a, busy_a, done_a;
    logic [15:0] ram_a [0:7];

    // Instance B: 4-bit addresses, full address space
    logic        start_b, stop_b;
    logic [3:0]  end_b;
    logic        mem_en_b;
    logic [3:0]  mem_addr_b;
    logic [15:0] rdata_b;
    logic        audio_b, busy_b, done_b;
    logic [15:0] ram_b [0:15];

    playback_serializer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .CLK_DIV(4), .READ_LATENCY(1)) u_dut_a (
        .clock(clk), .reset(reset), .start(start_a), .stop(stop_a), .end_addr(end_a),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_rdata(rdata_a),
        .audio_out(audio_a), .busy(busy_a), .done(done_a)
    );

    playback_serializer #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLK_DIV(4), .READ_LATENCY(1)) u_dut_b (
        .clock(clk), .reset(reset), .start(start_b), .stop(stop_b), .end_addr(end_b),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(rdata_b),
        .audio_out(audio_b), .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) begin
        if (mem_en_a) rdata_a <= ram_a[mem_addr_a[2:0]];
        if (mem_en_b) rdata_b <= ram_b[mem_addr_b];
    end

    // Bus monitors: monotonic counters, bench compares against snapshots
    int          en_cnt_a = 0, done_cnt_a = 0, en_cnt_b = 0, done_cnt_b = 0;
    logic [15:0] addr_q_a[$];
    logic [3:0]  addr_q_b[$];
    always @(negedge clk) begin
        if (mem_en_a) begin en_cnt_a++; addr_q_a.push_back(mem_addr_a); end
        if (done_a)   done_cnt_a++;
        if (mem_en_b) begin en_cnt_b++; addr_q_b.push_back(mem_addr_b); end
        if (done_b)   done_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Accept at edge k, returns just after edge k+2 where word 0 appears
    task automatic accept_a(input logic [15:0] e, input string tag);
        start_a = 1'b1;
        end_a   = e;
        tick();
        chk({tag, "_acc_busy"}, 32'(busy_a), 32'd1);
        chk({tag, "_acc_en"},   32'(mem_en_a), 32'd1);
        chk({tag, "_acc_addr"}, 32'(mem_addr_a), 32'd0);
        start_a = 1'b0;
        tick();
        chk({tag, "_fetch_en"}, 32'(mem_en_a), 32'd0);
        chk({tag, "_fetch_out"}, 32'(audio_a), 32'd0);
        tick();
    endtask

    task automatic stream_a(input logic [47:0] bits, input int nbits, input int ncyc, input string tag);
        for (int c = 0; c < ncyc; c++) begin
            chk($sformatf("%s_bit_c%0d", tag, c), 32'(audio_a), 32'(bits[nbits-1-c/4]));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy_a), 32'd1);
            chk($sformatf("%s_done_c%0d", tag, c), 32'(done_a), 32'd0);
            tick();
        end
    endtask

    task automatic expect_done_a(input string tag);
        chk({tag, "_done"},      32'(done_a), 32'd1);
        chk({tag, "_busy_off"},  32'(busy_a), 32'd0);
        chk({tag, "_out_off"},   32'(audio_a), 32'd0);
        tick();
        chk({tag, "_done_once"}, 32'(done_a), 32'd0);
    endtask

    int          base_en, base_done, base_q;
    logic [47:0] pat;
    logic [15:0] w16;

    initial begin
        reset = 1'b1;
        start_a = 1'b0; stop_a = 1'b0; end_a = '0;
        start_b = 1'b0; stop_b = 1'b0; end_b = '0;
        for (int i = 0; i < 8; i++)  ram_a[i] = 16'h0000;
        for (int i = 0; i < 16; i++) ram_b[i] = 16'(i);
        tick();
        tick();
        chk("rst_out",  32'(audio_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_en",   32'(mem_en_a), 32'd0);
        chk("rst_addr", 32'(mem_addr_a), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single word
        ram_a[0] = 16'hA5F0;
        base_en = en_cnt_a; base_done = done_cnt_a;
        accept_a(16'd0, "t1");
        pat = 48'h0000_0000_A5F0;
        stream_a(pat, 16, 64, "t1");
        expect_done_a("t1");
        chk("t1_en_pulses", 32'(en_cnt_a - base_en), 32'd1);
        chk("t1_done_cnt",  32'(done_cnt_a - base_done), 32'd1);

        // 2: three contiguous words
        ram_a[0] = 16'hFFFF; ram_a[1] = 16'h0000; ram_a[2] = 16'h8001; ram_a[3] = 16'h5555;
        base_en = en_cnt_a; base_done = done_cnt_a; base_q = addr_q_a.size();
        accept_a(16'd2, "t2");
        pat = 48'hFFFF_0000_8001;
        stream_a(pat, 48, 192, "t2");
        expect_done_a("t2");
        for (int i = 0; i < 8; i++) tick();
        chk("t2_en_pulses", 32'(en_cnt_a - base_en), 32'd3);
        chk("t2_done_cnt",  32'(done_cnt_a - base_done), 32'd1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_addr%0d", i), 32'(addr_q_a[base_q+i]), 32'(i));

        // 3: stop during word 1, then replay from address 0
        base_done = done_cnt_a;
        accept_a(16'd2, "t3");
        stream_a(pat, 48, 72, "t3");
        stop_a = 1'b1;
        tick();
        chk("t3_stop_out",  32'(audio_a), 32'd0);
        chk("t3_stop_busy", 32'(busy_a), 32'd0);
        chk("t3_stop_done", 32'(done_a), 32'd0);
        chk("t3_stop_en",   32'(mem_en_a), 32'd0);
        stop_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t3_no_done", 32'(done_cnt_a - base_done), 32'd0);
        chk("t3_idle",    32'(busy_a), 32'd0);
        base_en = en_cnt_a;
        accept_a(16'd2, "t3r");
        stream_a(pat, 48, 20, "t3r");

        // 4: reset in the middle of word 0
        reset = 1'b1;
        tick();
        chk("t4_out",  32'(audio_a), 32'd0);
        chk("t4_busy", 32'(busy_a), 32'd0);
        chk("t4_done", 32'(done_a), 32'd0);
        chk("t4_en",   32'(mem_en_a), 32'd0);
        chk("t4_addr", 32'(mem_addr_a), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_no_fetch", 32'(en_cnt_a - base_en), 32'd2);
        chk("t4_still_idle", 32'(busy_a), 32'd0);
        ram_a[0] = 16'h1234;
        accept_a(16'd0, "t4p");
        pat = 48'h0000_0000_1234;
        stream_a(pat, 16, 64, "t4p");
        expect_done_a("t4p");

        // 5: start held while busy and through the done edge; start+stop in idle
        ram_a[0] = 16'hA5F0;
        pat = 48'h0000_0000_A5F0;
        base_en = en_cnt_a;
        start_a = 1'b1;
        end_a   = 16'd0;
        tick();
        chk("t5_acc_busy", 32'(busy_a), 32'd1);
        tick();
        tick();
        stream_a(pat, 16, 64, "t5");
        chk("t5_done",      32'(done_a), 32'd1);
        chk("t5_done_busy", 32'(busy_a), 32'd0);
        chk("t5_done_en",   32'(mem_en_a), 32'd0);
        chk("t5_one_fetch", 32'(en_cnt_a - base_en), 32'd1);
        tick();
        chk("t5_re_busy", 32'(busy_a), 32'd1);
        chk("t5_re_en",   32'(mem_en_a), 32'd1);
        chk("t5_re_addr", 32'(mem_addr_a), 32'd0);
        chk("t5_re_done", 32'(done_a), 32'd0);
        start_a = 1'b0;
        tick();
        tick();
        stream_a(pat, 16, 64, "t5r");
        expect_done_a("t5r");
        base_en = en_cnt_a;
        start_a = 1'b1;
        stop_a  = 1'b1;
        tick();
        chk("t5_ss_busy", 32'(busy_a), 32'd0);
        chk("t5_ss_en",   32'(mem_en_a), 32'd0);
        tick();
        chk("t5_ss_busy2", 32'(busy_a), 32'd0);
        start_a = 1'b0;
        stop_a  = 1'b0;
        tick();
        chk("t5_ss_nofetch", 32'(en_cnt_a - base_en), 32'd0);

        // 6: 4-bit address space, end_addr = all ones
        base_en = en_cnt_b; base_done = done_cnt_b; base_q = addr_q_b.size();
        start_b = 1'b1;
        end_b   = 4'hF;
        tick();
        chk("t6_acc_busy", 32'(busy_b), 32'd1);
        chk("t6_acc_en",   32'(mem_en_b), 32'd1);
        start_b = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 1024; c++) begin
            w16 = 16'(c / 64);
            chk($sformatf("t6_bit_c%0d", c), 32'(audio_b), 32'(w16[15 - (c/4) % 16]));
            chk($sformatf("t6_done_c%0d", c), 32'(done_b), 32'd0);
            tick();
        end
        chk("t6_done",     32'(done_b), 32'd1);
        chk("t6_busy_off", 32'(busy_b), 32'd0);
        chk("t6_addr_hold", 32'(mem_addr_b), 32'hF);
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("t6_en_pulses", 32'(en_cnt_b - base_en), 32'd16);
        chk("t6_done_cnt",  32'(done_cnt_b - base_done), 32'd1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t6_addr%0d", i), 32'(addr_q_b[base_q+i]), 32'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
